// File: rtl/bram_stream_pkg.sv
// Shared types and helpers for the BRAM ping-pong stream writer.
// Optional header stamping is controlled by HDR_STAMP_EN.
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT_FREE
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  function automatic logic [31:0] pack_addr(
    input logic        half,
    input logic [29:0] idx,
    input int          iw
  );
    logic [31:0] h;
    h = {31'd0, half};
    return (h << (iw + 2)) | {idx, 2'b00};
  endfunction

endpackage

// File: rtl/bram_stream_writer_if.sv
// Stream and BRAM Port A bundles for the stream writer.
// Stream side is a plain valid/ready handshake.
interface stream_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave (input s_data, input s_valid, output s_ready);
endinterface

interface bram_port_if #(
  parameter int AW = 16
);
  logic          bram_clk;
  logic          bram_rst;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_din;
  logic [31:0]   bram_dout;

  modport master (
    output bram_clk, output bram_rst, output bram_en,
    output bram_we, output bram_addr, output bram_din,
    input bram_dout
  );
  modport slave (
    input bram_clk, input bram_rst, input bram_en,
    input bram_we, input bram_addr, input bram_din,
    output bram_dout
  );
endinterface

// File: rtl/bram_stream_writer_half_flags.sv
// Per-half full flags; a set in the same cycle as a release wins.
module bram_half_flags (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] set_i,
  input  logic [1:0] release_i,
  output logic [1:0] full_o
);

  logic [1:0] full_q, full_d;

  assign full_d = set_i | (full_q & ~release_i);
  assign full_o = full_q;

  always_ff @(posedge clk) begin
    if (rst) full_q <= 2'b00;
    else     full_q <= full_d;
  end

endmodule

// File: rtl/bram_stream_writer.sv
// Ping-pong stream writer into BRAM Port A.
// Define HDR_STAMP_EN to stamp a sequence header into word 0 of each half.
module bram_stream_writer
  import bram_stream_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 16,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int HALF_WORDS      = 2**(BRAM_ADDR_WIDTH-3)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [1:0]                  half_release,
  output logic [1:0]                  half_full,
  output logic                        half_done,
  output logic                        done_half,
  output logic [$clog2(HALF_WORDS):0] fill_words,
  output logic                        active_half,
  stream_if.slave                     s,
  bram_port_if.master                 bram
);

  localparam int IW = $clog2(HALF_WORDS);
  localparam int FW = IW + 1;

  state_t                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic                         act_q, act_d;
  logic                         hd_q, hd_d;
  logic                         dh_q, dh_d;
  logic [FW-1:0]                fw_q, fw_d;
  logic                         en_q, en_d;
  logic [3:0]                   we_q, we_d;
  logic [BRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BRAM_DATA_WIDTH-1:0]   din_q, din_d;
  logic [1:0]                   set_full;
  logic                         ready, accept, last, close;
  logic [BRAM_ADDR_WIDTH-1:0]   waddr;
  logic [FW-1:0]                fill_nxt;
  logic                         unused_dout;

  bram_half_flags u_flags (
    .clk       (clk),
    .rst       (rst),
    .set_i     (set_full),
    .release_i (half_release),
    .full_o    (half_full)
  );

`ifdef HDR_STAMP_EN
  logic [15:0] seq_q, seq_d;
  logic        hdr_cyc;

  assign hdr_cyc = (state_q == WRITE) && enable &&
                   !half_full[act_q] && (idx_q == '0);
  assign ready = (state_q == WRITE) && !half_full[act_q] &&
                 (idx_q != '0);
`else
  assign ready = (state_q == WRITE) && !half_full[act_q];
`endif

  assign accept   = s.s_valid && ready;
  assign last     = idx_q == IW'(HALF_WORDS - 1);
  assign waddr    = BRAM_ADDR_WIDTH'(pack_addr(act_q, 30'(idx_q), IW));
  assign fill_nxt = {1'b0, idx_q} + FW'(1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    act_d    = act_q;
    hd_d     = 1'b0;
    dh_d     = dh_q;
    fw_d     = fw_q;
    en_d     = 1'b0;
    we_d     = 4'h0;
    addr_d   = addr_q;
    din_d    = din_q;
    set_full = 2'b00;
    close    = 1'b0;
`ifdef HDR_STAMP_EN
    seq_d    = seq_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = WRITE;
      end
      WRITE: begin
`ifdef HDR_STAMP_EN
        if (hdr_cyc) begin
          en_d   = 1'b1;
          we_d   = 4'hF;
          addr_d = waddr;
          din_d  = {HDR_MAGIC, 8'h00, seq_q};
          idx_d  = IW'(1);
        end
`endif
        if (accept) begin
          en_d   = 1'b1;
          we_d   = 4'hF;
          addr_d = waddr;
          din_d  = s.s_data;
          idx_d  = idx_q + IW'(1);
        end
        if (accept && last) begin
          close = 1'b1;
          fw_d  = FW'(HALF_WORDS);
        end else if (!enable && (accept || idx_q != '0)) begin
          // partial half is handed to the host as-is
          close = 1'b1;
          fw_d  = accept ? fill_nxt : {1'b0, idx_q};
        end
        if (close) begin
          set_full[act_q] = 1'b1;
          hd_d  = 1'b1;
          dh_d  = act_q;
          act_d = ~act_q;
          idx_d = '0;
`ifdef HDR_STAMP_EN
          seq_d = seq_q + 16'd1;
`endif
        end
        if (!enable)
          state_d = IDLE;
        else if (close && half_full[~act_q])
          state_d = WAIT_FREE;
      end
      WAIT_FREE: begin
        if (!enable)
          state_d = IDLE;
        else if (!half_full[act_q])
          state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      act_q   <= 1'b0;
      hd_q    <= 1'b0;
      dh_q    <= 1'b0;
      fw_q    <= '0;
      en_q    <= 1'b0;
      we_q    <= 4'h0;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef HDR_STAMP_EN
      seq_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      hd_q    <= hd_d;
      dh_q    <= dh_d;
      fw_q    <= fw_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef HDR_STAMP_EN
      seq_q   <= seq_d;
`endif
    end
  end

  assign s.s_ready      = ready;
  assign half_done      = hd_q;
  assign done_half      = dh_q;
  assign fill_words     = fw_q;
  assign active_half    = act_q;
  assign bram.bram_clk  = clk;
  assign bram.bram_rst  = rst;
  assign bram.bram_en   = en_q;
  assign bram.bram_we   = we_q;
  assign bram.bram_addr = addr_q;
  assign bram.bram_din  = din_q;
  assign unused_dout    = ^bram.bram_dout;

endmodule
